fir_decim_out: RTL and testbench

- Downstream stage of the N-tap FIR filter.
- Consumes one signed filtered sample per valid cycle.
- Performs integrate-and-dump decimation by DECIM: sums DECIM samples, then divides by DECIM with rounding.
- Buffers results in a small FIFO and presents them to the consumer on a valid/ready handshake, with a sticky overflow flag.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_decim_out_if.sv | 38 +++
 rtl/fir_sample_fifo.sv | 63 ++++++
 rtl/fir_decim_out.sv | 94 +++++++++
 tb/tb_fir_decim_out.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample type, width helper and parameter legality checks for the FIR output stage
package fir_pkg;

  localparam int FIR_DATA_WIDTH     = 8;
  localparam int FIR_DECIM_MIN      = 2;
  localparam int FIR_FIFO_DEPTH_MIN = 2;

  typedef logic signed [FIR_DATA_WIDTH-1:0] fir_sample_t;

  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit decim_legal(input int decim);
    return (decim >= FIR_DECIM_MIN) && is_pow2(decim);
  endfunction

  function automatic bit fifo_depth_legal(input int depth);
    return (depth >= FIR_FIFO_DEPTH_MIN) && is_pow2(depth);
  endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// rtl/fir_decim_out_if.sv - sample input, decimated output handshake and status; FIR_DECIM_BYPASS_EN adds bypass
interface fir_decim_out_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
);
  localparam int FILL_W = fill_w(FIFO_DEPTH);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [FILL_W-1:0]            fill;
  logic                         overflow;
  logic                         ovf_clr;
`ifdef FIR_DECIM_BYPASS_EN
  logic                         bypass;

  modport master (
    output in_valid, in_data, out_ready, ovf_clr, bypass,
    input  out_valid, out_data, fill, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr, bypass,
    output out_valid, out_data, fill, overflow
  );
`else
  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  out_valid, out_data, fill, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output out_valid, out_data, fill, overflow
  );
`endif

endinterface

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - first-word-fall-through sample FIFO with a registered head that holds when empty
module fir_sample_fifo import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic signed [DATA_WIDTH-1:0] push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [fill_w(DEPTH)-1:0]     fill,
  output logic signed [DATA_WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = fill_w(DEPTH);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]                rd_ptr, wr_ptr, rd_next;
  logic [FW-1:0]                cnt, cnt_after_pop;
  logic                         do_push, do_pop;
  logic signed [DATA_WIDTH-1:0] head_next;

  assign empty         = (cnt == '0);
  assign full          = (cnt == FW'(DEPTH));
  assign fill          = cnt;
  assign do_pop        = pop && !empty;
  assign do_push       = push && (!full || do_pop);
  assign rd_next       = rd_ptr + AW'(do_pop);
  assign cnt_after_pop = cnt - FW'(do_pop);

  // Head tracks the next entry to present; if nothing remains it keeps the last value shown.
  always_comb begin
    head_next = head;
    if (cnt_after_pop != '0) begin
      head_next = mem[rd_next];
    end else if (do_push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(do_push);
      cnt    <= cnt_after_pop + FW'(do_push);
      head   <= head_next;
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - integrate-and-dump decimator with rounding, output FIFO and sticky overflow; FIR_DECIM_BYPASS_EN adds bypass
module fir_decim_out import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  fir_decim_out_if.slave io
);
  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = DATA_WIDTH + SHIFT + 1;
  localparam logic [SHIFT-1:0]        PHASE_LAST = SHIFT'(DECIM - 1);
  localparam logic signed [ACC_W-1:0] HALF       = ACC_W'(DECIM / 2);

  if (!decim_legal(DECIM) || !fifo_depth_legal(FIFO_DEPTH)) begin : g_param_check
    $error("fir_decim_out: DECIM and FIFO_DEPTH must be powers of two, at least 2");
  end

  logic [SHIFT-1:0]             phase;
  logic signed [ACC_W-1:0]      acc, sum, rounded;
  logic signed [DATA_WIDTH-1:0] dump_data, push_data;
  logic                         push, pop, full, empty, drop, overflow;

  assign sum       = acc + {{(SHIFT + 1){io.in_data[DATA_WIDTH-1]}}, io.in_data};
  assign rounded   = sum + HALF;
  // DECIM samples averaged always fit DATA_WIDTH, so plain truncation after the shift is safe.
  assign dump_data = DATA_WIDTH'(rounded >>> SHIFT);

  always_comb begin
    push      = io.in_valid && (phase == PHASE_LAST);
    push_data = dump_data;
`ifdef FIR_DECIM_BYPASS_EN
    if (io.bypass) begin
      push      = io.in_valid;
      push_data = io.in_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      acc   <= '0;
`ifdef FIR_DECIM_BYPASS_EN
    end else if (io.bypass) begin
      if (io.in_valid) begin
        phase <= '0;
        acc   <= '0;
      end
`endif
    end else if (io.in_valid) begin
      if (phase == PHASE_LAST) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + SHIFT'(1);
        acc   <= sum;
      end
    end
  end

  assign pop  = !empty && io.out_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (io.ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  fir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .fill      (io.fill),
    .head      (io.out_data)
  );

  assign io.out_valid = !empty;
  assign io.overflow  = overflow;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb/tb_fir_decim_out.sv - scoreboard bench for fir_decim_out with directed vectors
module tb_fir_decim_out;
  import fir_pkg::*;

  localparam int DW = 8;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];

  fir_decim_out_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) io ();

  fir_decim_out #(
    .DATA_WIDTH (DW),
    .DECIM      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0d, expected no output", $signed(io.out_data));
      end else begin
        check("out_data", $signed(io.out_data), exp_q.pop_front());
      end
    end
  end

  task automatic send(input int v);
    io.in_valid = 1'b1;
    io.in_data  = DW'(v);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    io.out_ready = 1'b1;
    while (io.fill != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, int'(k < 50), 1);
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    io.ovf_clr   = 1'b0;
`ifdef FIR_DECIM_BYPASS_EN
    io.bypass    = 1'b0;
`endif
    idle(3);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", $signed(io.out_data), 0);
    check("rst_fill", io.fill, 0);
    check("rst_overflow", io.overflow, 0);
    reset = 1'b1;
    idle(2);

    // Basic decimation and 1-clock latency
    io.out_ready = 1'b1;
    exp_q.push_back(7);
    send(12);
    send(-8);
    send(7);
    io.in_valid = 1'b1;
    io.in_data  = DW'(15);
    @(negedge clk);
    check("lat_before", io.out_valid, 0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", io.out_valid, 1);
    @(negedge clk);
    check("lat_one_cycle", io.out_valid, 0);
    idle(1);

    // Negative rounding
    exp_q.push_back(-5);
    send(-5);
    send(-5);
    send(-5);
    send(-6);
    idle(3);

    // Gapped input
    exp_q.push_back(127);
    for (int i = 0; i < 3; i++) begin
      send(127);
      idle(2);
    end
    check("gap_no_early_valid", io.out_valid, 0);
    check("gap_no_early_fill", io.fill, 0);
    send(127);
    idle(3);

    // Overflow: five dumps into a 4-deep FIFO with no consumer
    io.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(4);
    for (int i = 0; i < 20; i++) send(4);
    check("ovf_fill", io.fill, 4);
    check("ovf_flag", io.overflow, 1);
    check("ovf_head", $signed(io.out_data), 4);
    drain("ovf_drain");
    check("ovf_drain_count", exp_q.size(), 0);
    check("ovf_sticky", io.overflow, 1);
    io.out_ready = 1'b0;
    io.ovf_clr   = 1'b1;
    idle(1);
    io.ovf_clr   = 1'b0;
    check("ovf_clr", io.overflow, 0);

    // Full FIFO: push and pop on the same cycle
    for (int v = 1; v <= 5; v++) exp_q.push_back(v);
    for (int v = 1; v <= 4; v++) begin
      repeat (4) send(v);
    end
    check("full_fill", io.fill, 4);
    send(5);
    send(5);
    send(5);
    io.out_ready = 1'b1;
    send(5);
    io.out_ready = 1'b0;
    check("pushpop_fill", io.fill, 4);
    check("pushpop_no_ovf", io.overflow, 0);
    drain("pushpop_drain");

    // Asynchronous reset mid-accumulation
    io.out_ready = 1'b1;
    send(10);
    send(10);
    #3;
    reset = 1'b0;
    #1;
    check("async_out_valid", io.out_valid, 0);
    check("async_out_data", $signed(io.out_data), 0);
    check("async_fill", io.fill, 0);
    check("async_overflow", io.overflow, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(1);
    repeat (4) send(1);
    idle(3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
